// File: rtl/conv_pkg.sv
// Shared types, dimensions and the pixel-address helper for the convolution engine.
package conv_pkg;

  localparam int unsigned PIX_W   = 4;
  localparam int unsigned IMG_DIM = 4;
  localparam int unsigned K_DIM   = 3;
  localparam int unsigned OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int unsigned ACC_W   = 11;

  localparam int unsigned N_PIX   = IMG_DIM * IMG_DIM;
  localparam int unsigned N_TAPS  = K_DIM * K_DIM;
  localparam int unsigned N_OUT   = OUT_DIM * OUT_DIM;

  localparam int unsigned ADDR_W  = $clog2(N_PIX);
  localparam int unsigned TAP_W   = $clog2(N_TAPS);
  localparam int unsigned OIDX_W  = $clog2(N_OUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    EMIT,
    DONE
  } state_t;

  // Flat image index of kernel tap 'tap' for output position 'pix' (row-major both).
  function automatic logic [ADDR_W-1:0] addr(input logic [OIDX_W-1:0] pix,
                                             input logic [TAP_W-1:0]  tap);
    int unsigned r, c, i, j;
    r = 32'(pix) / OUT_DIM;
    c = 32'(pix) % OUT_DIM;
    i = 32'(tap) / K_DIM;
    j = 32'(tap) % K_DIM;
    return ADDR_W'((r + i) * IMG_DIM + (c + j));
  endfunction

endpackage

// File: rtl/multiplier_4x4.sv
// Unsigned 4x4 -> 8-bit combinational multiplier shared by the MAC sequencer.
module multiplier_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  assign o_p = 8'(i_a) * 8'(i_b);

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequences one shared multiplier over a 3x3 kernel sliding across a 4x4 image,
// one multiply-accumulate per clock, streaming the 2x2 results over valid/ready.
module conv_mac_sequencer
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PIX_W*N_PIX-1:0]   image,
  input  logic [PIX_W*N_TAPS-1:0]  kernel,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [OIDX_W-1:0]        out_idx,
  output logic                     done
);

  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(N_TAPS - 1);
  localparam logic [OIDX_W-1:0] LAST_PIX = OIDX_W'(N_OUT - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [PIX_W*N_PIX-1:0]    r_img;
  logic [PIX_W*N_TAPS-1:0]   r_ker;
  logic [ACC_W-1:0]          r_acc;
  logic [TAP_W-1:0]          r_tap;
  logic [OIDX_W-1:0]         r_pix;

  logic [ADDR_W-1:0]         w_addr;
  logic [PIX_W-1:0]          w_img_px;
  logic [PIX_W-1:0]          w_ker_tap;
  logic [2*PIX_W-1:0]        w_prod;
  logic                      w_accept;

  // Operands come straight from the latched frame; the product is not registered.
  assign w_addr    = addr(r_pix, r_tap);
  assign w_img_px  = r_img[w_addr*PIX_W +: PIX_W];
  assign w_ker_tap = r_ker[r_tap*PIX_W +: PIX_W];
  assign w_accept  = (r_state == EMIT) && out_ready;

  multiplier_4x4 u_mult (
    .i_a (w_img_px),
    .i_b (w_ker_tap),
    .o_p (w_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: one LOAD cycle, K_DIM^2 MAC cycles per result, EMIT until accepted.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = MAC;
      MAC:     if (r_tap == LAST_TAP) w_next = EMIT;
      EMIT:    if (out_ready) w_next = (r_pix == LAST_PIX) ? DONE : MAC;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: frame latch, tap/pixel counters and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_tap <= '0;
      r_pix <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          r_img <= image;
          r_ker <= kernel;
          r_acc <= '0;
          r_tap <= '0;
          r_pix <= '0;
        end
        MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (r_tap != LAST_TAP) r_tap <= r_tap + 1'b1;
        end
        EMIT: begin
          if (w_accept && (r_pix != LAST_PIX)) begin
            r_pix <= r_pix + 1'b1;
            r_acc <= '0;
            r_tap <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == EMIT);
  assign done      = (r_state == DONE);
  assign out_data  = r_acc;
  assign out_idx   = r_pix;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer: directed frames push expected results,
// a negedge monitor pops and compares every presented result.
module tb_conv_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] image;
  logic [35:0] kernel;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [1:0]  out_idx;
  logic        done;

  conv_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .image     (image),
    .kernel    (kernel),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_start = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push4(input int d0, input int d1, input int d2, input int d3);
    exp_t e;
    e.idx = 0; e.data = d0; q.push_back(e);
    e.idx = 1; e.data = d1; q.push_back(e);
    e.idx = 2; e.data = d2; q.push_back(e);
    e.idx = 3; e.data = d3; q.push_back(e);
  endtask

  // Monitor: every presented result is checked against the queue head; popped on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", int'(out_idx), -1);
        end else begin
          chk("out_idx", int'(out_idx), q[0].idx);
          chk("out_data", int'(out_data), q[0].data);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [63:0] img_fill(input logic [3:0] v);
    logic [63:0] r;
    for (int p = 0; p < 16; p++) r[4*p +: 4] = v;
    return r;
  endfunction

  function automatic logic [63:0] img_ramp();
    logic [63:0] r;
    for (int p = 0; p < 16; p++) r[4*p +: 4] = 4'(p);
    return r;
  endfunction

  function automatic logic [35:0] ker_fill(input logic [3:0] v);
    logic [35:0] r;
    for (int k = 0; k < 9; k++) r[4*k +: 4] = v;
    return r;
  endfunction

  function automatic logic [35:0] ker_one(input int tap);
    logic [35:0] r;
    r = '0;
    r[4*tap +: 4] = 4'd1;
    return r;
  endfunction

  // Pulse start for one edge; returns the cycle number of the sampling edge.
  task automatic pulse_start(output int n);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    start = 1'b0;
  endtask

  // Runs a started frame to completion. Timings are relative cycle numbers (N+k).
  // stall_idx: hold out_ready low 5 cycles when that index is first presented.
  // poke: pulse start while busy and overwrite the image after LOAD.
  task automatic run_frame(input int n, input int stall_idx, input bit poke,
                           output int t_valid, output int t_done);
    int stalled;
    int rel;
    t_valid = -1;
    t_done  = -1;
    stalled = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      rel = cyc + 1 - n;
      start = 1'b0;
      if (poke && rel == 4)  image = img_fill(4'd15);
      if (poke && (rel == 15 || rel == 21)) start = 1'b1;
      if (out_valid && t_valid < 0) t_valid = rel;
      if (out_valid && int'(out_idx) == stall_idx && stalled < 5) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        t_done = rel;
        break;
      end
    end
    start = 1'b0;
    chk("frame_completed", int'(t_done >= 0), 1);
  endtask

  int n, tv, td;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    image     = '0;
    kernel    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    // 1: all ones -> 9 each, exact timing.
    image = img_fill(4'd1); kernel = ker_fill(4'd1);
    push4(9, 9, 9, 9);
    pulse_start(n);
    chk("t1_busy_after_start", int'(busy), 1);
    run_frame(n, -1, 1'b0, tv, td);
    chk("t1_first_valid_cycle", tv, 11);
    chk("t1_done_cycle", td, 42);
    @(posedge clk); #1;
    chk("t1_busy_low_after_done", int'(busy), 0);
    chk("t1_queue_drained", q.size(), 0);

    // 2: all 15 -> 2025, no wrap.
    image = img_fill(4'd15); kernel = ker_fill(4'd15);
    push4(2025, 2025, 2025, 2025);
    pulse_start(n);
    run_frame(n, -1, 1'b0, tv, td);
    chk("t2_done_cycle", td, 42);
    chk("t2_queue_drained", q.size(), 0);

    // 3: identity kernel on ramp image.
    image = img_ramp(); kernel = ker_one(4);
    push4(5, 6, 9, 10);
    pulse_start(n);
    run_frame(n, -1, 1'b0, tv, td);
    chk("t3_queue_drained", q.size(), 0);

    // 4: ramp image, all-ones kernel, 5-cycle stall on idx 1.
    image = img_ramp(); kernel = ker_fill(4'd1);
    push4(45, 54, 81, 90);
    pulse_start(n);
    run_frame(n, 1, 1'b0, tv, td);
    chk("t4_done_cycle_stalled", td, 47);
    chk("t4_queue_drained", q.size(), 0);

    // 5: reset during MAC of idx 2 drops the frame.
    image = img_fill(4'd1); kernel = ker_fill(4'd1);
    push4(9, 9, 9, 9);
    void'(q.pop_back());
    void'(q.pop_back());
    pulse_start(n);
    tv = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (busy && !out_valid && out_idx == 2'd2) begin
        tv = 1;
        break;
      end
    end
    chk("t5_reached_mac_idx2", tv, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_out_idx", int'(out_idx), 0);
    chk("t5_rst_out_data", int'(out_data), 0);
    chk("t5_only_two_accepted", q.size(), 0);
    image = img_ramp(); kernel = ker_one(0);
    push4(0, 1, 4, 5);
    pulse_start(n);
    run_frame(n, -1, 1'b0, tv, td);
    chk("t5_fresh_done_cycle", td, 42);
    chk("t5_queue_drained", q.size(), 0);

    // 6: starts while busy and image overwritten after LOAD; start also held in DONE.
    image = img_fill(4'd2);
    for (int k = 0; k < 9; k++) kernel[4*k +: 4] = 4'(k + 1);
    push4(90, 90, 90, 90);
    pulse_start(n);
    run_frame(n, -1, 1'b1, tv, td);
    chk("t6_done_cycle", td, 42);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tv = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy || out_valid) tv = 1;
      @(posedge clk); #1;
    end
    chk("t6_no_restart", tv, 0);
    chk("t6_queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
